// File: rtl/traffic_sensor_conditioner.sv
// Conditions two bouncy, asynchronous vehicle-loop detector inputs into the
// clean Sa/Sb requests for traffic_light_controller. Each request is latched until that street gets green.

module tsc_channel #(
  parameter int DB_LEN = 4,
  parameter int PEND_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              raw,
  input  logic              green,
  output logic              req,
  output logic              pres,
  output logic [PEND_W-1:0] pend
);
  localparam int CW = $clog2(DB_LEN + 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DB_LEN - 1);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  logic          s1;
  logic          s2;
  logic [CW-1:0] dcnt;
  logic          arr;

  // arr marks the cycle in which pres is about to rise.
  assign arr = s2 & ~pres & (dcnt == DB_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      pres <= 1'b0;
      dcnt <= '0;
      pend <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;

      if (s2 == pres) begin
        dcnt <= '0;
      end else if (dcnt == DB_LAST) begin
        pres <= s2;
        dcnt <= '0;
      end else begin
        dcnt <= dcnt + CW'(1);
      end

      // Green clears even a same-cycle arrival: that vehicle is being served.
      if (green) begin
        pend <= '0;
      end else if (arr && (pend != PEND_MAX)) begin
        pend <= pend + PEND_W'(1);
      end
    end
  end

  assign req = pres | (pend != '0);
endmodule

module traffic_sensor_conditioner #(
  parameter int DB_LEN = 4,
  parameter int PEND_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              raw_a,
  input  logic              raw_b,
  input  logic              Ga,
  input  logic              Gb,
  output logic              Sa,
  output logic              Sb,
  output logic              pres_a,
  output logic              pres_b,
  output logic [PEND_W-1:0] pend_a,
  output logic [PEND_W-1:0] pend_b
);
  // The two streets are fully independent; simultaneous greens clear each one separately.
  tsc_channel #(.DB_LEN(DB_LEN), .PEND_W(PEND_W)) u_chan_a (
    .clk   (clk),
    .rst   (rst),
    .raw   (raw_a),
    .green (Ga),
    .req   (Sa),
    .pres  (pres_a),
    .pend  (pend_a)
  );

  tsc_channel #(.DB_LEN(DB_LEN), .PEND_W(PEND_W)) u_chan_b (
    .clk   (clk),
    .rst   (rst),
    .raw   (raw_b),
    .green (Gb),
    .req   (Sb),
    .pres  (pres_b),
    .pend  (pend_b)
  );
endmodule
